// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: frame-buffered, time-multiplexed 7-segment scanner with per-slot blanking dead-time.
// Optional brightness PWM on the digit enables when SEG7_SCAN_BRIGHTNESS_EN is defined.
module seg7_scan_mux #(
    parameter int NUM_OF_DISPLAYS = 6,
    parameter int SEG_WIDTH       = 8,
    parameter int REFRESH_DIV     = 1000,
    parameter int BLANK_CYCLES    = 4,
    parameter int LED_LOGIC       = 1
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      en_i,
`ifdef SEG7_SCAN_BRIGHTNESS_EN
    input  logic [3:0]                                brightness_i,
`endif
    input  logic [NUM_OF_DISPLAYS-1:0][SEG_WIDTH-1:0] seg7_i,
    output logic [SEG_WIDTH-1:0]                      seg_o,
    output logic [NUM_OF_DISPLAYS-1:0]                an_o,
    output logic [$clog2(NUM_OF_DISPLAYS)-1:0]        digit_idx_o,
    output logic                                      frame_tick_o
);
    localparam int IW = $clog2(NUM_OF_DISPLAYS);
    localparam int DW = $clog2(REFRESH_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] BLANK_LAST = DW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_OF_DISPLAYS - 1);
    localparam logic POL_INV = (LED_LOGIC == 0);
    localparam logic [SEG_WIDTH-1:0] SEG_OFF = {SEG_WIDTH{POL_INV}};
    localparam logic [NUM_OF_DISPLAYS-1:0] AN_OFF = {NUM_OF_DISPLAYS{POL_INV}};

    typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

    state_t                                r_state;
    state_t                                w_state_nxt;
    logic [DW-1:0]                         r_div;
    logic [DW-1:0]                         w_div_nxt;
    logic [IW-1:0]                         r_idx;
    logic [IW-1:0]                         w_idx_nxt;
    logic [NUM_OF_DISPLAYS-1:0][SEG_WIDTH-1:0] r_shadow;
    logic [NUM_OF_DISPLAYS-1:0][SEG_WIDTH-1:0] w_frame;
    logic [SEG_WIDTH-1:0]                  r_seg;
    logic [NUM_OF_DISPLAYS-1:0]            r_an;
    logic [NUM_OF_DISPLAYS-1:0]            w_onehot;
    logic                                  r_tick;
    logic                                  w_slot_end;
    logic                                  w_blank_end;
    logic                                  w_restart;
    logic                                  w_lit;

    // w_restart marks a shadow reload: leaving IDLE or finishing the last digit's slot
    always_comb begin
        w_slot_end  = (r_state == ON) && (r_div == DIV_LAST);
        w_blank_end = (r_state == BLANK) && (r_div == BLANK_LAST);
        w_restart   = en_i && ((r_state == IDLE) || (w_slot_end && r_idx == IDX_LAST));
        w_frame     = w_restart ? seg7_i : r_shadow;
        w_idx_nxt   = (!en_i || w_restart) ? '0 : w_slot_end ? r_idx + 1'b1 : r_idx;
        w_div_nxt   = (!en_i || r_state == IDLE || w_slot_end) ? '0 : r_div + 1'b1;
        w_state_nxt = !en_i ? IDLE
                    : (r_state == IDLE || w_slot_end) ? (BLANK_CYCLES == 0 ? ON : BLANK)
                    : w_blank_end ? ON : r_state;
        w_onehot    = {{(NUM_OF_DISPLAYS-1){1'b0}}, 1'b1} << w_idx_nxt;
    end

`ifdef SEG7_SCAN_BRIGHTNESS_EN
    logic [3:0] r_pwm;
    logic [3:0] r_bright;
    logic [3:0] w_pwm_nxt;
    logic [3:0] w_bright_nxt;
    logic       w_on_entry;

    // Each slot's ON phase restarts the PWM and latches a fresh brightness
    always_comb begin
        w_on_entry   = (w_state_nxt == ON) && (r_state != ON || w_slot_end);
        w_pwm_nxt    = w_on_entry ? 4'd0 : r_pwm + 4'd1;
        w_bright_nxt = w_on_entry ? brightness_i : r_bright;
        w_lit        = w_pwm_nxt <= w_bright_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pwm    <= '0;
            r_bright <= '0;
        end else begin
            r_pwm    <= w_pwm_nxt;
            r_bright <= w_bright_nxt;
        end
    end
`else
    assign w_lit = 1'b1;
`endif

    // Segments and anodes are registered together from the next state, so they never disagree
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_div    <= '0;
            r_idx    <= '0;
            r_shadow <= '0;
            r_seg    <= SEG_OFF;
            r_an     <= AN_OFF;
            r_tick   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_div    <= w_div_nxt;
            r_idx    <= w_idx_nxt;
            r_shadow <= w_frame;
            r_tick   <= w_restart;
            r_seg    <= (w_state_nxt == ON) ? w_frame[w_idx_nxt] ^ SEG_OFF : SEG_OFF;
            r_an     <= (w_state_nxt == ON && w_lit) ? w_onehot ^ AN_OFF : AN_OFF;
        end
    end

    assign seg_o        = r_seg;
    assign an_o         = r_an;
    assign digit_idx_o  = r_idx;
    assign frame_tick_o = r_tick;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: randomized scenario bench for seg7_scan_mux against a time-based frame model.
// Brightness checks are built only when SEG7_SCAN_BRIGHTNESS_EN is defined.
module tb_seg7_scan_mux;
    localparam int N = 6;
    localparam int W = 8;
    localparam int DIV = 8;
    localparam int BLK = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic [N-1:0][W-1:0] seg7 = '0;
    logic [W-1:0] seg_p, seg_n;
    logic [N-1:0] an_p, an_n;
    logic [2:0] idx_p, idx_n;
    logic tick_p, tick_n;
    int errors = 0;
    int checks = 0;

    // Model: cycles elapsed since the scan started, plus the frame captured at each frame start
    int m_p = -1;
    logic [N-1:0][W-1:0] m_frame = '0;

    always #5 clk = ~clk;

    seg7_scan_mux #(.NUM_OF_DISPLAYS(N), .SEG_WIDTH(W), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLK), .LED_LOGIC(1)) dut_p (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
`ifdef SEG7_SCAN_BRIGHTNESS_EN
        .brightness_i(4'hF),
`endif
        .seg7_i(seg7), .seg_o(seg_p), .an_o(an_p), .digit_idx_o(idx_p), .frame_tick_o(tick_p));

    seg7_scan_mux #(.NUM_OF_DISPLAYS(N), .SEG_WIDTH(W), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLK), .LED_LOGIC(0)) dut_n (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
`ifdef SEG7_SCAN_BRIGHTNESS_EN
        .brightness_i(4'hF),
`endif
        .seg7_i(seg7), .seg_o(seg_n), .an_o(an_n), .digit_idx_o(idx_n), .frame_tick_o(tick_n));

`ifdef SEG7_SCAN_BRIGHTNESS_EN
    logic [3:0] bright = 4'd3;
    logic [W-1:0] seg_b;
    logic [N-1:0] an_b;
    logic [2:0] idx_b;
    logic tick_b;
    seg7_scan_mux #(.NUM_OF_DISPLAYS(N), .SEG_WIDTH(W), .REFRESH_DIV(34), .BLANK_CYCLES(2), .LED_LOGIC(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .brightness_i(bright),
        .seg7_i(seg7), .seg_o(seg_b), .an_o(an_b), .digit_idx_o(idx_b), .frame_tick_o(tick_b));
`endif

    always @(posedge clk) begin
        if (!rst_n || !en) m_p = -1;
        else begin
            m_p = m_p + 1;
            if (m_p % (N * DIV) == 0) m_frame = seg7;
        end
    end

    // Expected {seg, an, idx, tick} for the active-high instance
    function automatic logic [17:0] model_out();
        int k;
        logic on;
        if (m_p < 0) return '0;
        k = (m_p / DIV) % N;
        on = (m_p % DIV) >= BLK;
        return {on ? m_frame[k] : 8'h00, on ? 6'(1 << k) : 6'h00, 3'(k), m_p % (N * DIV) == 0};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        for (int i = 0; i < N; i++) seg7[i] = 8'(8'h10 + i);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({seg_p, an_p, idx_p, tick_p} !== 18'h0) begin
                errors++;
                $display("FAIL reset_high: got %h expected %h", {seg_p, an_p, idx_p, tick_p}, 18'h0);
            end
            checks++;
            if ({seg_n, an_n, idx_n, tick_n} !== {8'hFF, 6'h3F, 3'd0, 1'b0}) begin
                errors++;
                $display("FAIL reset_low: got %h expected %h", {seg_n, an_n, idx_n, tick_n}, {8'hFF, 6'h3F, 3'd0, 1'b0});
            end
        end
    endtask

    task automatic test_scan_order();
        int last = -1;
        int ticks = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 2 * N * DIV; i++) begin
            @(negedge clk);
            checks++;
            if ({seg_p, an_p, idx_p, tick_p} !== model_out()) begin
                errors++;
                $display("FAIL scan cycle %0d: got %h expected %h", i, {seg_p, an_p, idx_p, tick_p}, model_out());
            end
            if (tick_p) begin
                ticks++;
                if (last >= 0) begin
                    checks++;
                    if (i - last != N * DIV) begin
                        errors++;
                        $display("FAIL tick_period: got %0d expected %0d", i - last, N * DIV);
                    end
                end
                last = i;
            end
        end
        checks++;
        if (ticks != 2) begin
            errors++;
            $display("FAIL tick_count: got %0d expected 2", ticks);
        end
    endtask

    task automatic test_tear_free();
        int budget = 0;
        while (idx_p != 3'd2 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (idx_p != 3'd2) begin
            errors++;
            $display("FAIL tear_wait_idx2: got %0d expected 2", idx_p);
        end
        for (int i = 0; i < N; i++) seg7[i] = 8'hFF;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
            checks++;
            if ({seg_p, an_p, idx_p, tick_p} !== model_out()) begin
                errors++;
                $display("FAIL tear_model: got %h expected %h", {seg_p, an_p, idx_p, tick_p}, model_out());
            end
            if (!tick_p && an_p != '0 && idx_p >= 3'd3) begin
                checks++;
                if (seg_p !== 8'(8'h10 + idx_p)) begin
                    errors++;
                    $display("FAIL tear_old_frame digit %0d: got %h expected %h", idx_p, seg_p, 8'(8'h10 + idx_p));
                end
            end
        end while (!tick_p && budget < 100);
        checks++;
        if (!tick_p) begin
            errors++;
            $display("FAIL tear_wait_tick: got 0 expected 1");
        end
        for (int i = 0; i < N * DIV; i++) begin
            @(negedge clk);
            if (an_p != '0) begin
                checks++;
                if (seg_p !== 8'hFF) begin
                    errors++;
                    $display("FAIL tear_new_frame: got %h expected ff", seg_p);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        int budget = 0;
        logic [17:0] want [3];
        want[0] = {8'h00, 6'h00, 3'd0, 1'b1};
        want[1] = {8'h00, 6'h00, 3'd0, 1'b0};
        want[2] = {8'h10, 6'h01, 3'd0, 1'b0};
        for (int i = 0; i < N; i++) seg7[i] = 8'(8'h10 + i);
        while (!(idx_p == 3'd3 && an_p != '0) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (!(idx_p == 3'd3 && an_p != '0)) begin
            errors++;
            $display("FAIL drop_wait_digit3: got idx %0d an %b expected idx 3 lit", idx_p, an_p);
        end
        en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({seg_p, an_p, idx_p, tick_p} !== 18'h0) begin
                errors++;
                $display("FAIL drop_idle: got %h expected %h", {seg_p, an_p, idx_p, tick_p}, 18'h0);
            end
        end
        en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({seg_p, an_p, idx_p, tick_p} !== want[c]) begin
                errors++;
                $display("FAIL drop_restart cycle %0d: got %h expected %h", c, {seg_p, an_p, idx_p, tick_p}, want[c]);
            end
        end
    endtask

    task automatic test_led_low();
        logic [13:0] want;
        @(negedge clk);
        rst_n = 1'b0;
        seg7[0] = 8'h3F;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < DIV; c++) begin
            @(negedge clk);
            want = (c < BLK) ? {8'hFF, 6'b111111} : {8'hC0, 6'b111110};
            checks++;
            if ({seg_n, an_n} !== want || idx_n !== 3'd0 || tick_n !== (c == 0)) begin
                errors++;
                $display("FAIL led_low cycle %0d: got seg %h an %b idx %0d tick %b expected %h idx 0 tick %b",
                         c, seg_n, an_n, idx_n, tick_n, want, c == 0);
            end
        end
    endtask

    task automatic test_random();
        logic [17:0] exp;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            exp = model_out();
            checks++;
            if ({seg_p, an_p, idx_p, tick_p} !== exp) begin
                errors++;
                $display("FAIL rand_high cycle %0d: got %h expected %h", i, {seg_p, an_p, idx_p, tick_p}, exp);
            end
            checks++;
            if ({seg_n, an_n, idx_n, tick_n} !== (exp ^ {8'hFF, 6'h3F, 4'h0})) begin
                errors++;
                $display("FAIL rand_low cycle %0d: got %h expected %h", i, {seg_n, an_n, idx_n, tick_n}, exp ^ {8'hFF, 6'h3F, 4'h0});
            end
            checks++;
            if ($countones(an_p) > 1) begin
                errors++;
                $display("FAIL rand_onehot: got %b expected at most one bit", an_p);
            end
            if ($urandom_range(0, 7) == 0) seg7[$urandom_range(0, N - 1)] = 8'($urandom);
            en = ($urandom_range(0, 149) != 0) ? 1'b1 : 1'b0;
            rst_n = ($urandom_range(0, 399) != 0) ? 1'b1 : 1'b0;
        end
    endtask

`ifdef SEG7_SCAN_BRIGHTNESS_EN
    task automatic test_brightness();
        int budget = 0;
        int lit;
        logic [3:0] levels [2];
        int want [2];
        levels[0] = 4'd3;
        levels[1] = 4'd15;
        want[0] = 8;
        want[1] = 32;
        rst_n = 1'b0;
        en = 1'b1;
        bright = levels[0];
        @(negedge clk);
        rst_n = 1'b1;
        while (!tick_b && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (!tick_b) begin
            errors++;
            $display("FAIL bright_wait_tick: got 0 expected 1");
        end
        for (int s = 0; s < 2; s++) begin
            lit = 0;
            for (int c = 0; c < 34; c++) begin
                if (c > 0) @(negedge clk);
                if (an_b != '0) lit++;
            end
            if (s == 0) bright = levels[1];
            @(negedge clk);
            checks++;
            if (lit != want[s]) begin
                errors++;
                $display("FAIL bright_level %0d: got %0d lit cycles expected %0d", levels[s], lit, want[s]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scan_order();
        test_tear_free();
        test_enable_drop();
        test_led_low();
        test_random();
`ifdef SEG7_SCAN_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
